// File: rtl/sev_disp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sev_disp_pkg
// Brief    : FSM states, segment constants and sizing helper for the display path
// Revision : 1.0
// ============================================================================
package sev_disp_pkg;

  localparam logic [1:0] C_ST_IDLE   = 2'd0;
  localparam logic [1:0] C_ST_SHIFT  = 2'd1;
  localparam logic [1:0] C_ST_FINISH = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = C_ST_IDLE,
    ST_SHIFT  = C_ST_SHIFT,
    ST_FINISH = C_ST_FINISH
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low gfedcba patterns, digit 0 in the low 7 bits
  localparam logic [69:0] SEG_TABLE = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                       7'h19, 7'h30, 7'h24, 7'h79, 7'h40};

  function automatic int bcd_digits(input int w);
    return (w + 2) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sev_seg_encode.sv
`default_nettype none
// ============================================================================
// Module   : sev_seg_encode
// Brief    : BCD nibble to active-low seven-segment pattern (non-decimal = blank)
// Revision : 1.0
// ============================================================================
module sev_seg_encode
  import sev_disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (nib <= 4'd9) seg = SEG_TABLE[7*nib +: 7];
  end

endmodule
`default_nettype wire

// File: rtl/multi_digit_sev_disp.sv
`default_nettype none
// ============================================================================
// Module   : multi_digit_sev_disp
// Brief    : Sequential double-dabble binary to multi-digit 7-segment driver.
//            Optional build macro: LEAD_ZERO_BLANK_EN (blank leading zeros).
// Revision : 1.0
// ============================================================================
module multi_digit_sev_disp
  import sev_disp_pkg::*;
#(
  parameter int BIN_W      = 8,
  parameter int NUM_DIGITS = 3,
  parameter int SIGNED_IN  = 0
) (
  input  logic                    clock,
  input  logic                    rstIn,
  input  logic                    start,
  input  logic [BIN_W-1:0]        binIn,
  output logic                    busy,
  output logic                    done,
  output logic                    ovf,
  output logic                    neg,
  output logic [4*NUM_DIGITS-1:0] bcdOut,
  output logic [7*NUM_DIGITS-1:0] segAll
);

  localparam int C_CONV  = bcd_digits(BIN_W);
  localparam int C_AVAIL = NUM_DIGITS - SIGNED_IN;
  localparam int C_EXT   = (C_CONV > NUM_DIGITS) ? C_CONV : NUM_DIGITS;
  localparam int C_CNT_W = $clog2(BIN_W);
  localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(BIN_W - 1);

`ifdef LEAD_ZERO_BLANK_EN
  localparam logic C_LZB = 1'b1;
`else
  localparam logic C_LZB = 1'b0;
`endif

  state_e                  r_state;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [BIN_W-1:0]        r_mag;
  logic [4*C_CONV-1:0]     r_acc;
  logic                    r_sign;

  logic                    w_neg;
  logic [BIN_W-1:0]        w_mag;
  logic [4*C_CONV-1:0]     w_adj;
  logic                    w_unused_msb;
  logic [4*C_EXT-1:0]      w_ext;
  logic                    w_ovf;
  logic                    w_seen;
  logic [4*NUM_DIGITS-1:0] w_bcd;
  logic [7*NUM_DIGITS-1:0] w_enc;
  logic [7*NUM_DIGITS-1:0] w_seg;

  // Negating the most negative value wraps to 2^(BIN_W-1), which is exactly its magnitude
  assign w_neg = (SIGNED_IN != 0) && binIn[BIN_W-1];
  assign w_mag = w_neg ? (~binIn + {{(BIN_W-1){1'b0}}, 1'b1}) : binIn;

  always_comb begin
    w_adj = r_acc;
    for (int i = 0; i < C_CONV; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  // The accumulator is sized so its top bit can never carry out
  assign w_unused_msb = w_adj[4*C_CONV-1];

  always_comb begin
    w_ext = '0;
    w_ext[4*C_CONV-1:0] = r_acc;
    w_ovf = 1'b0;
    for (int i = C_AVAIL; i < C_EXT; i++) begin
      if (w_ext[4*i +: 4] != 4'd0) w_ovf = 1'b1;
    end
  end

  always_comb begin
    w_bcd = '1;
    if (!w_ovf) begin
      w_bcd = w_ext[4*NUM_DIGITS-1:0];
      if (SIGNED_IN != 0) w_bcd[4*NUM_DIGITS-1 -: 4] = r_sign ? 4'hA : 4'h0;
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_enc
    sev_seg_encode u_enc (
      .nib (w_ext[4*gi +: 4]),
      .seg (w_enc[7*gi +: 7])
    );
  end

  // Scan from the top digit down so leading zeros are known before each digit
  always_comb begin
    w_seg  = '1;
    w_seen = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (i >= C_AVAIL) begin
        w_seg[7*i +: 7] = r_sign ? SEG_DASH : SEG_BLANK;
      end else begin
        if ((w_ext[4*i +: 4] != 4'd0) || (i == 0)) w_seen = 1'b1;
        w_seg[7*i +: 7] = (C_LZB && !w_seen) ? SEG_BLANK : w_enc[7*i +: 7];
      end
      if (w_ovf) w_seg[7*i +: 7] = SEG_DASH;
    end
  end

  always_ff @(posedge clock or posedge rstIn) begin
    if (rstIn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_mag   <= '0;
      r_acc   <= '0;
      r_sign  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      neg     <= 1'b0;
      bcdOut  <= '0;
      segAll  <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_mag   <= w_mag;
            r_sign  <= w_neg;
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc <= {w_adj[4*C_CONV-2:0], r_mag[BIN_W-1]};
          r_mag <= r_mag << 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST) r_state <= ST_FINISH;
        end
        ST_FINISH: begin
          busy    <= 1'b0;
          done    <= 1'b1;
          ovf     <= w_ovf;
          neg     <= r_sign;
          bcdOut  <= w_bcd;
          segAll  <= w_seg;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_digit_sev_disp.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_digit_sev_disp
// Brief    : Scoreboard bench, unsigned and signed 8-bit / 3-digit instances
// Revision : 1.0
// ============================================================================
module tb_multi_digit_sev_disp;

`ifdef LEAD_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  typedef struct {
    logic [11:0] bcd;
    logic [20:0] seg;
    logic        ovf;
    logic        neg;
    int          due;
  } exp_t;

  logic        clock, rstIn;
  logic        start_u, start_s;
  logic [7:0]  bin_u, bin_s;
  logic        busy_u, done_u, ovf_u, neg_u;
  logic        busy_s, done_s, ovf_s, neg_s;
  logic [11:0] bcd_u, bcd_s;
  logic [20:0] seg_u, seg_s;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t q_u [$];
  exp_t q_s [$];
  exp_t last_u, last_s;

  multi_digit_sev_disp #(.BIN_W(8), .NUM_DIGITS(3), .SIGNED_IN(0)) dut_u (
    .clock(clock), .rstIn(rstIn), .start(start_u), .binIn(bin_u),
    .busy(busy_u), .done(done_u), .ovf(ovf_u), .neg(neg_u),
    .bcdOut(bcd_u), .segAll(seg_u)
  );

  multi_digit_sev_disp #(.BIN_W(8), .NUM_DIGITS(3), .SIGNED_IN(1)) dut_s (
    .clock(clock), .rstIn(rstIn), .start(start_s), .binIn(bin_s),
    .busy(busy_s), .done(done_s), .ovf(ovf_s), .neg(neg_s),
    .bcdOut(bcd_s), .segAll(seg_s)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic exp_t reset_exp();
    exp_t e;
    e.bcd = 12'h000; e.seg = {3{7'h7F}}; e.ovf = 1'b0; e.neg = 1'b0; e.due = 0;
    return e;
  endfunction

  task automatic monitor_one(input bit sel);
    exp_t e;
    logic d, b, o, n;
    logic [11:0] bc;
    logic [20:0] sg;
    d = sel ? done_s : done_u;  b = sel ? busy_s : busy_u;
    o = sel ? ovf_s  : ovf_u;   n = sel ? neg_s  : neg_u;
    bc = sel ? bcd_s : bcd_u;   sg = sel ? seg_s : seg_u;
    if (rstIn) begin
      if (sel) last_s = reset_exp(); else last_u = reset_exp();
    end else if (d) begin
      chk(sel ? "s_done_expected" : "u_done_expected", 64'((sel ? q_s.size() : q_u.size()) != 0), 64'd1);
      if ((sel ? q_s.size() : q_u.size()) != 0) begin
        e = sel ? q_s.pop_front() : q_u.pop_front();
        chk(sel ? "s_bcd" : "u_bcd", 64'(bc), 64'(e.bcd));
        chk(sel ? "s_seg" : "u_seg", 64'(sg), 64'(e.seg));
        chk(sel ? "s_ovf" : "u_ovf", 64'(o), 64'(e.ovf));
        chk(sel ? "s_neg" : "u_neg", 64'(n), 64'(e.neg));
        chk(sel ? "s_busy_at_done" : "u_busy_at_done", 64'(b), 64'd0);
        chk(sel ? "s_done_latency" : "u_done_latency", 64'(cyc), 64'(e.due));
        if (sel) last_s = e; else last_u = e;
      end
    end else begin
      e = sel ? last_s : last_u;
      chk(sel ? "s_hold" : "u_hold", {29'd0, o, n, bc, sg}, {29'd0, e.ovf, e.neg, e.bcd, e.seg});
    end
  endtask

  always @(negedge clock) begin
    monitor_one(1'b0);
    monitor_one(1'b1);
  end

  // Called at a negedge; returns at the negedge where done is seen
  task automatic conv(input bit sel, input logic [7:0] v, input logic [11:0] eb,
                      input logic [20:0] es, input logic eo, input logic en, input int glitch);
    exp_t e;
    bit   got;
    if (sel) begin start_s = 1'b1; bin_s = v; end
    else     begin start_u = 1'b1; bin_u = v; end
    @(posedge clock); #1;
    e.bcd = eb; e.seg = es; e.ovf = eo; e.neg = en; e.due = cyc + 9;
    chk(sel ? "s_busy_set" : "u_busy_set", 64'(sel ? busy_s : busy_u), 64'd1);
    if (sel) q_s.push_back(e); else q_u.push_back(e);
    got = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clock);
      if (sel) begin start_s = (n == glitch); if (n == glitch) bin_s = 8'd77; end
      else     begin start_u = (n == glitch); if (n == glitch) bin_u = 8'd77; end
      if (sel ? done_s : done_u) begin got = 1'b1; break; end
    end
    chk("done_timeout", 64'(got), 64'd1);
  endtask

  initial begin
    rstIn = 1'b1; start_u = 1'b0; start_s = 1'b0; bin_u = 8'd0; bin_s = 8'd0;
    last_u = reset_exp(); last_s = reset_exp();
    repeat (3) @(negedge clock);
    rstIn = 1'b0;
    chk("reset_u", {26'd0, busy_u, done_u, ovf_u, neg_u, bcd_u, seg_u}, {26'd0, 4'b0000, 12'h000, {3{7'h7F}}});
    chk("reset_s", {26'd0, busy_s, done_s, ovf_s, neg_s, bcd_s, seg_s}, {26'd0, 4'b0000, 12'h000, {3{7'h7F}}});
    @(negedge clock);

    conv(0, 8'd255, 12'h255, {7'h24, 7'h12, 7'h12}, 0, 0, 0);
    conv(0, 8'd0,   12'h000, LZB ? {7'h7F, 7'h7F, 7'h40} : {7'h40, 7'h40, 7'h40}, 0, 0, 0);
    conv(0, 8'd7,   12'h007, LZB ? {7'h7F, 7'h7F, 7'h78} : {7'h40, 7'h40, 7'h78}, 0, 0, 0);
    conv(0, 8'd42,  12'h042, LZB ? {7'h7F, 7'h19, 7'h24} : {7'h40, 7'h19, 7'h24}, 0, 0, 0);
    conv(0, 8'd100, 12'h100, {7'h79, 7'h40, 7'h40}, 0, 0, 0);
    // Start re-pulsed mid-conversion with 77 must be ignored
    conv(0, 8'd200, 12'h200, {7'h24, 7'h40, 7'h40}, 0, 0, 2);
    conv(0, 8'd77,  12'h077, LZB ? {7'h7F, 7'h78, 7'h78} : {7'h40, 7'h78, 7'h78}, 0, 0, 0);

    conv(1, 8'hF6,  12'hA10, {7'h3F, 7'h79, 7'h40}, 0, 1, 0);
    conv(1, 8'h80,  12'hFFF, {7'h3F, 7'h3F, 7'h3F}, 1, 1, 0);
    conv(1, 8'd99,  12'h099, {7'h7F, 7'h10, 7'h10}, 0, 0, 0);
    conv(1, 8'd5,   12'h005, LZB ? {7'h7F, 7'h7F, 7'h12} : {7'h7F, 7'h40, 7'h12}, 0, 0, 0);
    conv(1, 8'hFF,  12'hA01, LZB ? {7'h3F, 7'h7F, 7'h79} : {7'h3F, 7'h40, 7'h79}, 0, 1, 0);
    conv(1, 8'd100, 12'hFFF, {7'h3F, 7'h3F, 7'h3F}, 1, 0, 0);
    conv(1, 8'h9D,  12'hA99, {7'h3F, 7'h10, 7'h10}, 0, 1, 0);

    // Asynchronous abort in the middle of a conversion
    start_u = 1'b1; bin_u = 8'd123;
    @(posedge clock); #1 start_u = 1'b0;
    repeat (3) @(posedge clock);
    #2 rstIn = 1'b1;
    #1;
    chk("abort_busy", 64'(busy_u), 64'd0);
    chk("abort_seg",  64'(seg_u),  64'({3{7'h7F}}));
    chk("abort_bcd",  64'(bcd_u),  64'd0);
    chk("abort_s_seg", 64'(seg_s), 64'({3{7'h7F}}));
    repeat (2) @(negedge clock);
    rstIn = 1'b0;
    repeat (15) @(negedge clock);
    conv(0, 8'd123, 12'h123, {7'h79, 7'h24, 7'h30}, 0, 0, 0);

    repeat (5) @(negedge clock);
    chk("queue_u_empty", 64'(q_u.size()), 64'd0);
    chk("queue_s_empty", 64'(q_s.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
